demux1to4_reg: RTL
==================

Name: demux1to4_reg

Overview:
- Registered 1-to-4 demultiplexer with a valid/ready handshake on the input and on each of its four outputs.
- Steers one W-bit input word to the output channel chosen by select_in; it is the distribution counterpart of the 4-to-1 select mux.
- Used where the datapath fans one result out to one of four consumers, e.g. write-back routing or memory-mapped store targets.
- Each channel has a one-entry holding register, so consumers can stall independently.

Parameters:
- W, 32, data width in bits.
- DEFAULT_DATA, 32'h003FFFFC, reset/idle value of every dataN_out, truncated to W bits.

Ports:
- clk_in  input  1  single clock, rising edge.
- rst_n_in  input  1  reset, asynchronous assert, active-low.
- select_in  input  2  destination channel for the current input word.
- data_in  input  W  input word.
- valid_in  input  1  input word and select_in are valid.
- ready_out  output  1  input word accepted this cycle when valid_in && ready_out.
- data0_out..data3_out  output  W each  channel holding registers.
- valid0_out..valid3_out  output  1 each  channel N holds an undelivered word.
- ready0_in..ready3_in  input  1 each  consumer N takes its word when validN_out && readyN_in.

Behaviour:
- Reset is asynchronous and active-low on rst_n_in, released synchronously to clk_in.
- Values while rst_n_in = 0: validN_out = 0, dataN_out = DEFAULT_DATA. ready_out follows its combinational equation, so it is 1 during and immediately after reset.
- Per-channel FSM, 2 states:
  - EMPTY: validN_out = 0.
  - FULL: validN_out = 1.
- Definitions:
  - acceptN = valid_in && ready_out && (select_in == N).
  - drainN = validN_out && readyN_in.
- Transitions:
  - EMPTY -> FULL on acceptN.
  - FULL -> EMPTY on drainN && !acceptN.
  - FULL -> FULL on drainN && acceptN. The new word is loaded and validN_out stays 1 with no bubble.
  - FULL -> FULL with no load while !drainN.
- ready_out is combinational: ready_out = !valid[select_in] || ready[select_in]_in.
  - It depends only on the selected channel; the state of the other channels has no effect.
  - ready_out may be 1 while valid_in = 0.
- Data path:
  - On acceptN, dataN_out <= data_in at the next rising edge.
  - Latency from acceptance to validN_out = 1 is 1 clock.
  - dataN_out holds its last value after a drain; it is not cleared.
- Only one channel can load per cycle. Drains on all four channels in the same cycle are independent and allowed.
- Handshake rules:
  - Once validN_out = 1, dataN_out is stable until drainN.
  - No word is dropped or duplicated.
  - select_in and data_in are sampled only on acceptance.
- Reset mid-operation: all FULL channels return to EMPTY immediately and their pending words are discarded. No output handshake is generated.
- If W < 32, DEFAULT_DATA is truncated to its low W bits.

Optional Feature:
- Macro: DEMUX1TO4_COUNT_EN.
- When defined:
  - Adds output port accept_count_out [15:0].
  - It increments by 1 on every cycle with valid_in && ready_out, wraps 16'hFFFF -> 16'h0000, and resets to 0.
  - Adds output port stall_out [0:0], equal to valid_in && !ready_out.
- When undefined: neither port exists and no counter logic is built. All other behaviour is identical.

Test Plan:
1. Reset check: hold rst_n_in = 0 with valid_in = 1 toggling -> all validN_out = 0, all dataN_out = 32'h003FFFFC, ready_out = 1. Release reset -> no channel goes FULL until a valid_in cycle.
2. Single route: select_in = 2, data_in = 32'hDEADBEEF, valid_in = 1 for one cycle, ready2_in = 0.
   - Next cycle: valid2_out = 1 and data2_out = 32'hDEADBEEF; the other three channels stay invalid.
   - Set ready2_in = 1 for one cycle -> valid2_out = 0 and data2_out still reads 32'hDEADBEEF.
3. Backpressure:
   - Channel 1 FULL with 32'h11111111 and ready1_in = 0; present select_in = 1, data_in = 32'h22222222 -> ready_out = 0 and data1_out unchanged.
   - Switch select_in to 3 -> ready_out = 1 and 32'h22222222 lands in channel 3.
4. Back-to-back streaming: channel 0 with ready0_in held at 1, 8 consecutive valid words 1..8 -> valid0_out stays 1 for 8 consecutive cycles starting 1 cycle later, data0_out = 1..8 in order, ready_out never drops.
5. Reset mid-operation: fill all four channels, then assert rst_n_in = 0 asynchronously between clock edges -> all validN_out fall before the next edge and no drain is observed.
6. Count feature (DEMUX1TO4_COUNT_EN):
   - Preload 65534 accepts, then accept 3 more -> accept_count_out reads 16'hFFFF then 16'h0000 then 16'h0001.
   - stall_out = 1 exactly on cycles with valid_in = 1 and ready_out = 0.

Source files
------------

// File: rtl/demux1to4_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready on the input and on each output channel.
// Optional accept counter and stall flag when DEMUX1TO4_COUNT_EN is defined.
module demux1to4_reg #(
  parameter int unsigned W            = 32,
  parameter logic [31:0] DEFAULT_DATA = 32'h003FFFFC
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic [1:0]   select_in,
  input  logic [W-1:0] data_in,
  input  logic         valid_in,
  output logic         ready_out,
  output logic [W-1:0] data0_out,
  output logic [W-1:0] data1_out,
  output logic [W-1:0] data2_out,
  output logic [W-1:0] data3_out,
  output logic         valid0_out,
  output logic         valid1_out,
  output logic         valid2_out,
  output logic         valid3_out,
  input  logic         ready0_in,
  input  logic         ready1_in,
  input  logic         ready2_in,
  input  logic         ready3_in
`ifdef DEMUX1TO4_COUNT_EN
  ,
  output logic [15:0]  accept_count_out,
  output logic [0:0]   stall_out
`endif
);

  localparam int unsigned NCH = 4;
  localparam logic [W-1:0] DEF_DATA = W'(DEFAULT_DATA);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

  ch_state_t    state_q [NCH];
  logic [W-1:0] data_q  [NCH];

  logic [NCH-1:0] valid_ch;
  logic [NCH-1:0] ready_ch;
  logic [NCH-1:0] accept;
  logic [NCH-1:0] drain;

  assign ready_ch = {ready3_in, ready2_in, ready1_in, ready0_in};

  // Input is accepted whenever the selected channel is empty or draining this cycle.
  assign ready_out = !valid_ch[select_in] || ready_ch[select_in];

  always_comb begin
    valid_ch = '0;
    accept   = '0;
    drain    = '0;
    for (int i = 0; i < NCH; i++) begin
      valid_ch[i] = (state_q[i] == FULL);
      accept[i]   = valid_in && ready_out && (select_in == 2'(i));
      drain[i]    = valid_ch[i] && ready_ch[i];
    end
  end

  // Per-channel one-entry holding register; drain and reload in one cycle keeps FULL.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= EMPTY;
        data_q[i]  <= DEF_DATA;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        case (state_q[i])
          EMPTY: if (accept[i]) state_q[i] <= FULL;
          FULL:  if (drain[i] && !accept[i]) state_q[i] <= EMPTY;
        endcase
        if (accept[i]) data_q[i] <= data_in;
      end
    end
  end

  assign data0_out  = data_q[0];
  assign data1_out  = data_q[1];
  assign data2_out  = data_q[2];
  assign data3_out  = data_q[3];
  assign valid0_out = valid_ch[0];
  assign valid1_out = valid_ch[1];
  assign valid2_out = valid_ch[2];
  assign valid3_out = valid_ch[3];

`ifdef DEMUX1TO4_COUNT_EN
  logic [15:0] count_q;

  // Free-running accept counter, wraps naturally at 16 bits.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count_q <= '0;
    end else if (valid_in && ready_out) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign accept_count_out = count_q;
  assign stall_out        = valid_in && !ready_out;
`endif

endmodule
